// File: rtl/kmeans_pkg.sv
// Shared constants and types for the k-means core.
package kmeans_pkg;

  localparam int accum_cord_w     = 22;
  localparam int cordinate_w      = 13;
  localparam int count_w          = 10;
  localparam int centroid_n       = 8;
  localparam int coords_per_point = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    WRITE,
    DONE
  } new_means_state_t;

endpackage

// File: rtl/new_means_divider.sv
// Serial restoring divider: one quotient bit per cycle, quotient saturates
// when the upper dividend bits already reach the divisor.
module new_means_divider
  import kmeans_pkg::*;
#(
  parameter int dividend_width = accum_cord_w,
  parameter int quot_width     = cordinate_w,
  parameter int divisor_width  = count_w
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [dividend_width-1:0] dividend,
  input  logic [divisor_width-1:0]  divisor,
  output logic                      busy,
  output logic                      q_valid,
  output logic [quot_width-1:0]     quotient
);

  localparam int rem_w = divisor_width + 1;
  localparam int n_w   = $clog2(quot_width + 1);

  logic [rem_w-1:0]         rem_r;
  logic [divisor_width-1:0] div_r;
  logic [quot_width-1:0]    q_r;
  logic [quot_width-1:0]    sh_r;
  logic [n_w-1:0]           step_n;
  logic                     sat_r;

  logic [rem_w-1:0]         rem_in;
  logic                     bit_in;
  logic [divisor_width-1:0] dsr;
  logic [rem_w:0]           trial;
  logic [rem_w:0]           dsr_ext;
  logic                     ge;
  logic [rem_w-1:0]         rem_nx;
  logic                     sat_now;

  // The first iteration is folded into the load cycle, so a coordinate
  // occupies exactly quot_width cycles from load to q_valid.
  always_comb begin
    rem_in  = load ? rem_w'(dividend[dividend_width-1:quot_width]) : rem_r;
    bit_in  = load ? dividend[quot_width-1] : sh_r[quot_width-1];
    dsr     = load ? divisor : div_r;
    trial   = {rem_in, bit_in};
    dsr_ext = (rem_w + 1)'(dsr);
    ge      = (trial >= dsr_ext);
    rem_nx  = ge ? rem_w'(trial - dsr_ext) : rem_w'(trial);
    sat_now = (rem_w'(dividend[dividend_width-1:quot_width]) >= rem_w'(divisor));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r   <= '0;
      div_r   <= '0;
      q_r     <= '0;
      sh_r    <= '0;
      step_n  <= '0;
      sat_r   <= 1'b0;
      busy    <= 1'b0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      if (load) begin
        rem_r  <= rem_nx;
        div_r  <= divisor;
        q_r    <= quot_width'(ge);
        sh_r   <= {dividend[quot_width-2:0], 1'b0};
        sat_r  <= sat_now;
        step_n <= n_w'(1);
        busy   <= 1'b1;
      end else if (busy) begin
        rem_r  <= rem_nx;
        q_r    <= {q_r[quot_width-2:0], ge};
        sh_r   <= sh_r << 1;
        step_n <= step_n + 1'b1;
        if (step_n == n_w'(quot_width - 1)) begin
          busy    <= 1'b0;
          q_valid <= 1'b1;
        end
      end
    end
  end

  assign quotient = sat_r ? '1 : q_r;

endmodule

// File: rtl/new_means_block.sv
// Recomputes every centroid as accumulated sum / point count, one centroid
// at a time, and writes each result back with its index.
module new_means_block
  import kmeans_pkg::*;
#(
  parameter int accum_width      = coords_per_point * accum_cord_w,
  parameter int accum_cord_width = accum_cord_w,
  parameter int cordinate_width  = cordinate_w,
  parameter int dataWidth        = coords_per_point * cordinate_w,
  parameter int count_width      = count_w,
  parameter int centroid_num     = centroid_n
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [accum_width-1:0] accum_1,
  input  logic [accum_width-1:0] accum_2,
  input  logic [accum_width-1:0] accum_3,
  input  logic [accum_width-1:0] accum_4,
  input  logic [accum_width-1:0] accum_5,
  input  logic [accum_width-1:0] accum_6,
  input  logic [accum_width-1:0] accum_7,
  input  logic [accum_width-1:0] accum_8,
  input  logic [count_width-1:0] cnt_1,
  input  logic [count_width-1:0] cnt_2,
  input  logic [count_width-1:0] cnt_3,
  input  logic [count_width-1:0] cnt_4,
  input  logic [count_width-1:0] cnt_5,
  input  logic [count_width-1:0] cnt_6,
  input  logic [count_width-1:0] cnt_7,
  input  logic [count_width-1:0] cnt_8,
  input  logic [dataWidth-1:0]   centroid_reg_1,
  input  logic [dataWidth-1:0]   centroid_reg_2,
  input  logic [dataWidth-1:0]   centroid_reg_3,
  input  logic [dataWidth-1:0]   centroid_reg_4,
  input  logic [dataWidth-1:0]   centroid_reg_5,
  input  logic [dataWidth-1:0]   centroid_reg_6,
  input  logic [dataWidth-1:0]   centroid_reg_7,
  input  logic [dataWidth-1:0]   centroid_reg_8,
  output logic                   busy,
  output logic                   done,
  output logic                   new_centroid_valid,
  output logic [2:0]             cent_cnt,
  output logic [dataWidth-1:0]   new_centroid
);

  new_means_state_t state;

  logic [2:0]                  k;
  logic [2:0]                  c;
  logic [accum_width-1:0]      accum_r;
  logic [count_width-1:0]      cnt_r;
  logic [dataWidth-1:0]        result;

  logic [accum_width-1:0]      in_accum;
  logic [count_width-1:0]      in_cnt;
  logic [dataWidth-1:0]        creg_sel;
  logic [dataWidth-1:0]        res_next;

  logic                        div_load;
  logic                        div_busy;
  logic                        div_q_valid;
  logic [accum_cord_width-1:0] div_dividend;
  logic [count_width-1:0]      div_divisor;
  logic [cordinate_width-1:0]  div_quot;
  logic                        last_coord;

  always_comb begin
    in_accum = accum_1;
    in_cnt   = cnt_1;
    creg_sel = centroid_reg_1;
    unique case (k)
      3'd0: begin in_accum = accum_1; in_cnt = cnt_1; creg_sel = centroid_reg_1; end
      3'd1: begin in_accum = accum_2; in_cnt = cnt_2; creg_sel = centroid_reg_2; end
      3'd2: begin in_accum = accum_3; in_cnt = cnt_3; creg_sel = centroid_reg_3; end
      3'd3: begin in_accum = accum_4; in_cnt = cnt_4; creg_sel = centroid_reg_4; end
      3'd4: begin in_accum = accum_5; in_cnt = cnt_5; creg_sel = centroid_reg_5; end
      3'd5: begin in_accum = accum_6; in_cnt = cnt_6; creg_sel = centroid_reg_6; end
      3'd6: begin in_accum = accum_7; in_cnt = cnt_7; creg_sel = centroid_reg_7; end
      3'd7: begin in_accum = accum_8; in_cnt = cnt_8; creg_sel = centroid_reg_8; end
      default: ;
    endcase
  end

  assign last_coord = (c == 3'(coords_per_point - 1));

  // Coordinate 0 is loaded straight from the input mux during LOAD; each
  // later coordinate is loaded on the cycle the previous quotient lands.
  always_comb begin
    div_divisor  = (state == LOAD) ? in_cnt : cnt_r;
    div_dividend = '0;
    if (state == LOAD) begin
      div_dividend = in_accum[accum_cord_width-1:0];
    end else begin
      for (int unsigned i = 0; i < coords_per_point; i++) begin
        if (3'(i) == c + 3'd1)
          div_dividend = accum_r[i*accum_cord_width +: accum_cord_width];
      end
    end
    div_load = ((state == LOAD) && (in_cnt != '0)) ||
               ((state == DIV) && div_q_valid && !div_busy && !last_coord);
  end

  always_comb begin
    res_next = result;
    for (int unsigned i = 0; i < coords_per_point; i++) begin
      if (3'(i) == c)
        res_next[i*cordinate_width +: cordinate_width] = div_quot;
    end
  end

  new_means_divider #(
    .dividend_width (accum_cord_width),
    .quot_width     (cordinate_width),
    .divisor_width  (count_width)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .q_valid  (div_q_valid),
    .quotient (div_quot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      k                  <= '0;
      c                  <= '0;
      accum_r            <= '0;
      cnt_r              <= '0;
      result             <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      new_centroid_valid <= 1'b0;
      cent_cnt           <= '0;
      new_centroid       <= '0;
    end else begin
      new_centroid_valid <= 1'b0;
      done               <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            k     <= '0;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          accum_r <= in_accum;
          cnt_r   <= in_cnt;
          c       <= '0;
          if (in_cnt == '0) begin
            result             <= creg_sel;
            new_centroid       <= creg_sel;
            new_centroid_valid <= 1'b1;
            cent_cnt           <= k;
            state              <= WRITE;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          if (div_q_valid) begin
            result <= res_next;
            if (last_coord) begin
              new_centroid       <= res_next;
              new_centroid_valid <= 1'b1;
              cent_cnt           <= k;
              state              <= WRITE;
            end else begin
              c <= c + 3'd1;
            end
          end
        end
        WRITE: begin
          if (k == 3'(centroid_num - 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            k     <= k + 3'd1;
            state <= LOAD;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_new_means_block.sv
// Directed bench for new_means_block: a latency/quotient model predicts every
// output each cycle, and literal checks pin the key cycles and values.
module tb_new_means_block;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [153:0] accum_p [8];
  logic [9:0]   cnt_p   [8];
  logic [90:0]  creg_p  [8];
  logic        busy, done, new_centroid_valid;
  logic [2:0]  cent_cnt;
  logic [90:0] new_centroid;

  int acc_v  [8][7];
  int cnt_v  [8];
  int creg_v [8][7];

  bit          model_rst = 1'b1;
  bit          pass_active = 1'b0;
  int          pass_edge = 0;
  int          done_at = 0;
  int          write_at [8];
  logic [90:0] exp_val  [8];
  logic [2:0]  hold_cc = '0;
  logic [90:0] hold_nc = '0;

  int edge_count = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [90:0] lit100, lit3, litsat, litseq;

  new_means_block dut (
    .clk(clk), .rst(rst), .start(start),
    .accum_1(accum_p[0]), .accum_2(accum_p[1]), .accum_3(accum_p[2]), .accum_4(accum_p[3]),
    .accum_5(accum_p[4]), .accum_6(accum_p[5]), .accum_7(accum_p[6]), .accum_8(accum_p[7]),
    .cnt_1(cnt_p[0]), .cnt_2(cnt_p[1]), .cnt_3(cnt_p[2]), .cnt_4(cnt_p[3]),
    .cnt_5(cnt_p[4]), .cnt_6(cnt_p[5]), .cnt_7(cnt_p[6]), .cnt_8(cnt_p[7]),
    .centroid_reg_1(creg_p[0]), .centroid_reg_2(creg_p[1]), .centroid_reg_3(creg_p[2]),
    .centroid_reg_4(creg_p[3]), .centroid_reg_5(creg_p[4]), .centroid_reg_6(creg_p[5]),
    .centroid_reg_7(creg_p[6]), .centroid_reg_8(creg_p[7]),
    .busy(busy), .done(done), .new_centroid_valid(new_centroid_valid),
    .cent_cnt(cent_cnt), .new_centroid(new_centroid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_count <= edge_count + 1;

  task automatic cmp(input string name, input logic [90:0] act, input logic [90:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_count, act, exp);
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < 8; i++) begin
      cnt_p[i] = 10'(cnt_v[i]);
      for (int j = 0; j < 7; j++) begin
        accum_p[i][j*22 +: 22] = 22'(acc_v[i][j]);
        creg_p[i][j*13 +: 13]  = 13'(creg_v[i][j]);
      end
    end
  endtask

  // Each centroid costs LOAD+WRITE, plus 91 divide cycles when its count is non-zero.
  task automatic register_pass();
    int t;
    longint q;
    t = 0;
    for (int i = 0; i < 8; i++) begin
      t += (cnt_v[i] == 0) ? 2 : 93;
      write_at[i] = t;
      for (int j = 0; j < 7; j++) begin
        if (cnt_v[i] == 0) q = longint'(creg_v[i][j]);
        else begin
          q = longint'(acc_v[i][j]) / longint'(cnt_v[i]);
          if (q > 8191) q = 8191;
        end
        exp_val[i][j*13 +: 13] = 13'(q);
      end
    end
    done_at     = t + 1;
    pass_edge   = edge_count;
    pass_active = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (!model_rst && (!pass_active || (edge_count - pass_edge) > done_at))
      register_pass();
  endtask

  task automatic at_cycle(input int n);
    while (edge_count < pass_edge + n - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int n);
    at_cycle(n);
    @(negedge clk);
  endtask

  task automatic model_reset();
    model_rst   = 1'b1;
    pass_active = 1'b0;
    hold_cc     = '0;
    hold_nc     = '0;
  endtask

  always @(negedge clk) begin
    int   rel;
    logic eb, ed, ev;
    eb = 1'b0; ed = 1'b0; ev = 1'b0;
    if (!model_rst && pass_active) begin
      rel = edge_count - pass_edge + 1;
      eb  = (rel >= 1) && (rel <= done_at);
      ed  = (rel == done_at);
      for (int i = 0; i < 8; i++) begin
        if (write_at[i] == rel) begin
          ev      = 1'b1;
          hold_cc = 3'(i);
          hold_nc = exp_val[i];
        end
      end
    end
    cmp("busy", 91'(busy), 91'(eb));
    cmp("done", 91'(done), 91'(ed));
    cmp("new_centroid_valid", 91'(new_centroid_valid), 91'(ev));
    cmp("cent_cnt", 91'(cent_cnt), 91'(hold_cc));
    cmp("new_centroid", new_centroid, hold_nc);
  end

  initial begin
    lit100 = {7{13'd100}};
    lit3   = {7{13'd3}};
    litsat = {7{13'h1FFF}};
    litseq = {13'd7, 13'd6, 13'd5, 13'd4, 13'd3, 13'd2, 13'd1};
    for (int i = 0; i < 8; i++) begin
      cnt_v[i] = 0;
      for (int j = 0; j < 7; j++) begin
        acc_v[i][j]  = 0;
        creg_v[i][j] = 0;
      end
    end
    apply_inputs();
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("reset_busy", 91'(busy), 91'(0));
    cmp("reset_valid", 91'(new_centroid_valid), 91'(0));
    cmp("reset_nc", new_centroid, 91'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Pass A: all counts non-zero, divide and saturation corners.
    for (int j = 0; j < 7; j++) begin
      acc_v[0][j] = 400;      cnt_v[0] = 4;
      acc_v[1][j] = 10;       cnt_v[1] = 3;
      acc_v[2][j] = 4185601;  cnt_v[2] = 511;
      acc_v[3][j] = j*1000+7; cnt_v[3] = 1;
      acc_v[4][j] = 500000+j; cnt_v[4] = 1023;
      acc_v[5][j] = (j+1)*7777; cnt_v[5] = 7;
      acc_v[6][j] = j*1234;   cnt_v[6] = 1;
      acc_v[7][j] = (j+1)*12345; cnt_v[7] = 100;
      for (int i = 0; i < 8; i++) creg_v[i][j] = i*11 + j;
    end
    acc_v[3][0] = 2097152;
    acc_v[4][0] = 4194303; acc_v[4][1] = 1022; acc_v[4][2] = 1023;
    acc_v[5][0] = 6;
    acc_v[6][0] = 8191; acc_v[6][1] = 8192; acc_v[6][2] = 0;
    apply_inputs();
    pulse_start();
    at_neg(1);   cmp("A_busy_c1", 91'(busy), 91'(1));
    at_neg(92);  cmp("A_valid_c92", 91'(new_centroid_valid), 91'(0));
    at_neg(93);  cmp("A_valid_c93", 91'(new_centroid_valid), 91'(1));
                 cmp("A_cc_c93", 91'(cent_cnt), 91'(0));
                 cmp("A_nc_c93", new_centroid, lit100);
    at_neg(94);  cmp("A_valid_c94", 91'(new_centroid_valid), 91'(0));
                 cmp("A_hold_c94", new_centroid, lit100);
    at_neg(186); cmp("A_cc_c186", 91'(cent_cnt), 91'(1));
                 cmp("A_nc_trunc", new_centroid, lit3);
    at_neg(279); cmp("A_nc_exact8191", new_centroid, litsat);
    at_cycle(300);
    pulse_start();
    at_neg(744); cmp("A_done_c744", 91'(done), 91'(0));
    at_neg(745); cmp("A_done_c745", 91'(done), 91'(1));
                 cmp("A_busy_c745", 91'(busy), 91'(1));
    at_neg(746); cmp("A_busy_c746", 91'(busy), 91'(0));
                 cmp("A_cc_last", 91'(cent_cnt), 91'(7));

    // Pass B: zero count on centroid 2, started in the cycle after done.
    cnt_v[2] = 0;
    for (int j = 0; j < 7; j++) creg_v[2][j] = j + 1;
    apply_inputs();
    pulse_start();
    at_neg(187); cmp("B_valid_c187", 91'(new_centroid_valid), 91'(0));
    at_neg(188); cmp("B_valid_c188", 91'(new_centroid_valid), 91'(1));
                 cmp("B_cc_c188", 91'(cent_cnt), 91'(2));
                 cmp("B_nc_echo", new_centroid, litseq);
    at_neg(653); cmp("B_done_c653", 91'(done), 91'(0));
    at_neg(654); cmp("B_done_c654", 91'(done), 91'(1));
    at_neg(655); cmp("B_busy_c655", 91'(busy), 91'(0));

    // Pass C: reset in cycle 50 aborts the pass.
    cnt_v[2] = 50;
    apply_inputs();
    pulse_start();
    at_cycle(50);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    cmp("C_rst_busy", 91'(busy), 91'(0));
    @(posedge clk); #1;
    @(negedge clk);
    cmp("C_rst_nc", new_centroid, 91'(0));
    cmp("C_rst_valid", 91'(new_centroid_valid), 91'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;

    // Pass D: pseudo-random data, clean full pass after reset.
    for (int i = 0; i < 8; i++) begin
      cnt_v[i] = int'($urandom_range(1, 1023));
      for (int j = 0; j < 7; j++) begin
        acc_v[i][j]  = int'($urandom_range(0, 4194303));
        creg_v[i][j] = int'($urandom_range(0, 8191));
      end
    end
    cnt_v[5] = 1;
    apply_inputs();
    pulse_start();
    at_neg(93);  cmp("D_valid_c93", 91'(new_centroid_valid), 91'(1));
                 cmp("D_cc_c93", 91'(cent_cnt), 91'(0));
    at_neg(745); cmp("D_done_c745", 91'(done), 91'(1));
    at_neg(746); cmp("D_busy_c746", 91'(busy), 91'(0));
    repeat (5) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
